// File: rtl/mul_pow_if.sv
// mul_pow_if: operand/result bundle for the multiply/power engine.
// Uses the same in_valid/out_valid pulse handshake as the divide/root core.
interface mul_pow_if #(
    parameter int W1 = 10,
    parameter int W2 = 3,
    parameter int WO = 20
);
    logic          in_valid;
    logic          in_mode;
    logic [W1-1:0] in_data_1;
    logic [W2-1:0] in_data_2;
    logic          out_valid;
    logic [WO-1:0] out_data;
    logic          out_sat;

    modport master (
        output in_valid, in_mode, in_data_1, in_data_2,
        input  out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_mode, in_data_1, in_data_2,
        output out_valid, out_data, out_sat
    );
endinterface

// File: rtl/mul_pow_core.sv
// mul_pow_core: iterative shift-add multiply and saturating power.
// Single-issue; rebuilds dividend/radicand from a div/root operand pair.
module mul_pow_core #(
    parameter int W1 = 10,
    parameter int W2 = 3,
    parameter int WO = 20
) (
    input  logic     clk,
    input  logic     rst_n,
    mul_pow_if.slave bus
);
    localparam int WP = W1 + WO;
    localparam logic [W2-1:0] MUL_K = W2[W2-1:0];

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_q;
    logic          mode_q;
    logic          sat_q;
    logic [W2-1:0] b_q;
    logic [W2-1:0] cnt_q;
    logic [WO-1:0] m_q;
    logic [WO-1:0] acc_q;
    logic          out_valid_q;
    logic [WO-1:0] out_data_q;
    logic          out_sat_q;

    logic [WP-1:0] prod;
    logic          ovf;
    logic [WO-1:0] nxt_acc;
    logic          nxt_sat;

    // One step: shift-add for multiply, full-width product for power.
    always_comb begin
        prod    = WP'(acc_q) * WP'(m_q);
        ovf     = sat_q || (|prod[WP-1:WO]);
        nxt_acc = acc_q;
        nxt_sat = 1'b0;
        if (mode_q) begin
            nxt_sat = ovf;
            nxt_acc = ovf ? '1 : prod[WO-1:0];
        end else if (b_q[0]) begin
            nxt_acc = acc_q + m_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            sat_q       <= 1'b0;
            b_q         <= '0;
            cnt_q       <= '0;
            m_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        m_q    <= WO'(bus.in_data_1);
                        b_q    <= bus.in_data_2;
                        mode_q <= bus.in_mode;
                        sat_q  <= 1'b0;
                        if (!bus.in_mode) begin
                            acc_q   <= '0;
                            cnt_q   <= MUL_K;
                            state_q <= CALC;
                        end else if (bus.in_data_2 == '0) begin
                            // x**0 = 1, including 0**0
                            acc_q       <= WO'(1);
                            cnt_q       <= '0;
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= WO'(1);
                            out_sat_q   <= 1'b0;
                        end else begin
                            acc_q   <= WO'(1);
                            cnt_q   <= bus.in_data_2;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= nxt_acc;
                    sat_q <= nxt_sat;
                    cnt_q <= cnt_q - 1'b1;
                    if (!mode_q) begin
                        m_q <= m_q << 1;
                        b_q <= b_q >> 1;
                    end
                    if (cnt_q == W2'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= nxt_acc;
                        out_sat_q   <= nxt_sat;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                    out_sat_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
endmodule
